// File: rtl/kalman_sample_feeder_pkg.sv
`default_nettype none
// =============================================================================
// kalman_sample_feeder_pkg : feeder FSM encoding and sample-to-fixed conversion
// Rev 1.0
// =============================================================================
package kalman_sample_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GUARD = 3'd5
  } feeder_state_e;

  // Integer sample shifted into fixed point, clamped to a data_bits-wide signed range.
  function automatic logic signed [63:0] to_fixed(input logic signed [63:0] sample,
                                                  input int unsigned       frac_bits,
                                                  input int unsigned       data_bits);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = sample <<< frac_bits;
    max_v   = (64'sd1 <<< (data_bits - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v) return max_v;
    if (shifted < min_v) return min_v;
    return shifted;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kalman_sample_fifo.sv
`default_nettype none
// =============================================================================
// kalman_sample_fifo : count-based synchronous FIFO for raw samples
// Rev 1.0
// =============================================================================
module kalman_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kalman_sample_feeder.sv
`default_nettype none
// =============================================================================
// kalman_sample_feeder : buffers raw samples, issues them to the Kalman filter
// in fixed point and forwards each filtered result. Rev 1.0
// =============================================================================
module kalman_sample_feeder
  import kalman_sample_feeder_pkg::*;
#(
  parameter int IN_WIDTH        = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int FIX_POINT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic                  kf_valid,
  output logic [DATA_WIDTH-1:0] kf_data,
  input  logic                  kf_finish,
  input  logic [DATA_WIDTH-1:0] kf_result,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  feeder_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] kf_data_q, kf_data_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IN_WIDTH-1:0]   fifo_rdata;

  kalman_sample_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && !fifo_full),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign kf_valid    = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign kf_data     = kf_data_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    kf_data_d     = kf_data_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;
    fifo_pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        kf_data_d = DATA_WIDTH'(to_fixed(64'(signed'(fifo_rdata)), FIX_POINT_WIDTH, DATA_WIDTH));
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      // A finish on the final allowed cycle still wins over the timeout.
      ST_WAIT: begin
        if (kf_finish) begin
          out_data_d  = kf_result;
          out_valid_d = 1'b1;
          state_d     = ST_GUARD;
        end else if (wait_cnt_q == LAST_WAIT) begin
          timeout_err_d = 1'b1;
          state_d       = ST_GUARD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kf_data_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      kf_data_q     <= kf_data_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kalman_sample_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_kalman_sample_feeder : randomized bench with queue-based reference model
// Rev 1.0
// =============================================================================
module tb_kalman_sample_feeder;
  localparam int IN_W  = 16;
  localparam int DW    = 32;
  localparam int FIX   = 16;
  localparam int DEPTH = 8;
  localparam int TMO   = 255;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic            in_ready, kf_valid, out_valid, busy, timeout_err;
  logic [DW-1:0]   kf_data, out_data;
  logic            kf_finish;
  logic [DW-1:0]   kf_result;

  logic            filt_finish = 1'b0;
  logic [DW-1:0]   filt_result = '0;
  logic            spur_finish = 1'b0;
  assign kf_finish = filt_finish | spur_finish;
  assign kf_result = spur_finish ? 32'hDEAD_BEEF : filt_result;

  int n_checks = 0;
  int n_errors = 0;

  kalman_sample_feeder #(
    .IN_WIDTH(IN_W), .DATA_WIDTH(DW), .FIX_POINT_WIDTH(FIX),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .kf_valid(kf_valid), .kf_data(kf_data), .kf_finish(kf_finish), .kf_result(kf_result),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sample times 2^FIX, clamped to the DW-bit signed range.
  function automatic logic [DW-1:0] conv(input logic [IN_W-1:0] s);
    longint v, lim;
    v   = longint'($signed(s)) * (longint'(1) <<< FIX);
    lim = longint'(1) <<< (DW - 1);
    if (v > lim - 1) v = lim - 1;
    if (v < -lim)    v = -lim;
    return v[DW-1:0];
  endfunction

  // Reference model state
  logic [IN_W-1:0] exp_samples[$];
  logic [DW-1:0]   exp_results[$];
  int              cyc = 0;
  bit              pending = 0;
  int              issue_cyc = 0;
  int              exp_ov_cyc = -1;
  bit              te_model = 0;
  bit              prev_kv = 0;
  logic [DW-1:0]   last_issued = '0;
  int              issued_cnt = 0;
  int              ov_cnt = 0;

  bit              filt_enable = 1;
  bit              force_res_en = 0;
  logic [DW-1:0]   force_res = '0;
  int              filt_lat_min = 1;
  int              filt_lat_max = 4;

  // Monitor: everything observed mid-cycle describes the cycle in progress.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_samples.delete();
      exp_results.delete();
      pending    = 0;
      exp_ov_cyc = -1;
      te_model   = 0;
      prev_kv    = 0;
    end else begin
      if (pending && kf_finish && cyc > issue_cyc && cyc <= issue_cyc + TMO) begin
        exp_results.push_back(kf_result);
        exp_ov_cyc = cyc + 1;
        pending    = 0;
      end else if (pending && cyc == issue_cyc + TMO + 1) begin
        te_model = 1;
        pending  = 0;
      end
      check("timeout_err", timeout_err, te_model);
      if (out_valid || cyc == exp_ov_cyc) begin
        check("out_valid", out_valid, cyc == exp_ov_cyc);
        if (out_valid) begin
          ov_cnt++;
          check("out_pending", exp_results.size(), 1);
          if (exp_results.size() != 0) check("out_data", out_data, exp_results.pop_front());
          check("kf_data_hold", kf_data, last_issued);
        end
      end
      if (kf_valid) begin
        check("kf_valid_width", prev_kv, 0);
        check("kf_issue_queue", exp_samples.size() != 0, 1);
        if (exp_samples.size() != 0) begin
          last_issued = conv(exp_samples.pop_front());
          check("kf_data", kf_data, last_issued);
        end
        pending   = 1;
        issue_cyc = cyc;
        issued_cnt++;
      end
      prev_kv = kf_valid;
      if (in_valid && in_ready) exp_samples.push_back(in_data);
    end
  end

  // Filter model: answers each start pulse after a random latency.
  initial forever begin
    @(negedge clk);
    if (kf_valid && !rst && filt_enable) begin
      int lat;
      lat = $urandom_range(filt_lat_max, filt_lat_min);
      repeat (lat) @(posedge clk);
      #1;
      if (!rst) begin
        filt_finish = 1'b1;
        filt_result = force_res_en ? force_res : $urandom;
      end
      @(posedge clk);
      #1 filt_finish = 1'b0;
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sample(input logic [IN_W-1:0] d, output bit stalled);
    int n;
    n        = 0;
    stalled  = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      stalled = 1;
      n++;
      @(negedge clk);
    end
    check("push_accepted", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_samples.size() != 0 || pending) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle_cycles(3);
    check("drain_bound", n < 3000, 1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"},    in_ready, 1);
    check({pfx, "_kf_valid"},    kf_valid, 0);
    check({pfx, "_kf_data"},     kf_data, 0);
    check({pfx, "_out_valid"},   out_valid, 0);
    check({pfx, "_out_data"},    out_data, 0);
    check({pfx, "_busy"},        busy, 0);
    check({pfx, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int n, ic0, ovc, first_stall;
    bit stalled;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    idle_cycles(1);

    // Single positive sample with a fixed filter answer
    force_res_en = 1; force_res = 32'h0004_8000;
    filt_lat_min = 3; filt_lat_max = 3;
    in_data = 16'h0005; in_valid = 1'b1; n = 0;
    do begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      n++;
    end while (!kf_valid && n < 10);
    check("issue_latency", n, 3);
    check("kf_data_pos", kf_data, 32'h0005_0000);
    wait_idle();
    check("out_data_pos", out_data, 32'h0004_8000);
    force_res_en = 0;

    push_sample(16'hFFFD, stalled);
    wait_idle();
    check("kf_data_neg", kf_data, 32'hFFFD_0000);

    // Spurious finish while idle
    ovc = ov_cnt;
    spur_finish = 1'b1;
    idle_cycles(1);
    spur_finish = 1'b0;
    idle_cycles(3);
    check("spurious_busy", busy, 0);
    check("spurious_out", ov_cnt, ovc);

    // Back-to-back burst against a slow filter
    filt_lat_min = 20; filt_lat_max = 20;
    ic0 = issued_cnt; first_stall = -1;
    for (int k = 0; k < 10; k++) begin
      push_sample(IN_W'($urandom), stalled);
      if (stalled && first_stall < 0) first_stall = k;
    end
    check("burst_accept_before_full", first_stall, 9);
    wait_idle();
    check("burst_issued", issued_cnt - ic0, 10);

    // Timeout, then the next queued sample must still go out
    filt_enable = 0; filt_lat_min = 2; filt_lat_max = 6;
    ic0 = issued_cnt; ovc = ov_cnt;
    push_sample(16'h0011, stalled);
    push_sample(16'h0022, stalled);
    n = 0;
    while (!timeout_err && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_seen", timeout_err, 1);
    filt_enable = 1;
    wait_idle();
    check("timeout_next_issued", issued_cnt - ic0, 2);
    check("timeout_one_result", ov_cnt - ovc, 1);

    // Randomized traffic including the extreme samples
    filt_lat_min = 1; filt_lat_max = 8;
    ic0 = issued_cnt;
    for (int k = 0; k < 40; k++) begin
      push_sample((k == 0) ? 16'h7FFF : (k == 1) ? 16'h8000 : IN_W'($urandom), stalled);
      idle_cycles($urandom_range(6, 0));
    end
    wait_idle();
    check("random_issued", issued_cnt - ic0, 40);

    // Reset in WAIT with three samples still queued
    filt_enable = 0;
    ic0 = issued_cnt;
    for (int k = 0; k < 4; k++) push_sample(IN_W'($urandom), stalled);
    idle_cycles(5);
    check("pre_reset_issued", issued_cnt - ic0, 1);
    check("pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    ic0 = issued_cnt;
    idle_cycles(20);
    check("post_reset_no_issue", issued_cnt, ic0);
    check("post_reset_busy", busy, 0);
    check("post_reset_in_ready", in_ready, 1);
    filt_enable = 1;
    push_sample(16'h0007, stalled);
    wait_idle();
    check("post_reset_kf_data", kf_data, 32'h0007_0000);
    check("post_reset_issued", issued_cnt - ic0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
